// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, data word type and receiver
// state encoding. Imported by the receive path and its bit timer.
package uart_pkg;

  typedef logic [7:0] uart_data_t;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  // Shortest bit period accepted; smaller baud_count values are raised to it.
  localparam int UART_MIN_BAUD_COUNT = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  // Data bits per frame: 5..8 pass through, anything else means 8.
  function automatic logic [3:0] uart_eff_data_bits(input logic [3:0] bits);
    return ((bits >= 4'd5) && (bits <= 4'd8)) ? bits : 4'd8;
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Loadable down-counter that times bit periods for the UART receiver.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (count cleared)
//   load        - load strobe; load_value takes priority over counting
//   load_value  - cycles until the next expire pulse
//   en          - count enable
//   expire      - high in the cycle that is load_value cycles after a load
module uart_rx_bit_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  // A load of N shows N in the following cycle, so N cycles after the load
  // the count has reached 1.
  assign expire = en && (count == WIDTH'(1));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx, detects the start bit, samples each bit
// mid-period and assembles a 5..8 bit word with optional parity.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   rx           - asynchronous serial line, idles high
//   baud_count   - clk cycles per bit (values below 4 act as 4)
//   data_bits    - data bits per frame (5..8, otherwise 8)
//   parity_en    - a parity bit follows the data
//   odd_parity   - 1 = odd parity, 0 = even parity
//   rx_data      - received word, right-aligned, upper bits zero
//   rx_valid     - one-cycle pulse when a frame completes
//   parity_err   - parity mismatch on the last frame (held)
//   frame_err    - stop bit sampled low on the last frame (held)
//   busy         - receiver is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BAUD_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic [BAUD_WIDTH-1:0] baud_count,
  input  logic [3:0]            data_bits,
  input  logic                  parity_en,
  input  logic                  odd_parity,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);

  uart_rx_state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic                   rx_q;
  logic                   fall;

  logic [BAUD_WIDTH-1:0]  period_in;
  logic [BAUD_WIDTH-1:0]  half_in;
  logic [BAUD_WIDTH-1:0]  period_q;
  logic [3:0]             bits_q;
  logic                   par_en_q;
  logic                   odd_q;

  logic                   tmr_load;
  logic [BAUD_WIDTH-1:0]  tmr_val;
  logic                   expire;

  logic [2:0]             bit_cnt;
  logic                   last_bit;
  uart_data_t             shreg;
  logic                   par_acc;
  logic                   perr_q;

  // Input synchroniser; reset to the idle level so no false start follows.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '1;
      rx_q <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
      rx_q <= rx_s;
    end
  end

  assign rx_s = sync[SYNC_STAGES-1];
  assign fall = rx_q && !rx_s;

  assign period_in = (baud_count < BAUD_WIDTH'(UART_MIN_BAUD_COUNT)) ?
                     BAUD_WIDTH'(UART_MIN_BAUD_COUNT) : baud_count;
  assign half_in   = period_in >> 1;

  assign last_bit = ({1'b0, bit_cnt} == (bits_q - 4'd1));

  uart_rx_bit_timer #(
    .WIDTH (BAUD_WIDTH)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_val),
    .en         (busy),
    .expire     (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    tmr_load = 1'b0;
    tmr_val  = period_q;
    case (state)
      IDLE: begin
        if (fall) begin
          state_n  = START;
          tmr_load = 1'b1;
          tmr_val  = half_in;
        end
      end
      START: begin
        if (expire) begin
          if (rx_s == UART_START_BIT) begin
            state_n  = DATA;
            tmr_load = 1'b1;
          end else begin
            state_n  = IDLE;
          end
        end
      end
      DATA: begin
        if (expire) begin
          tmr_load = 1'b1;
          if (last_bit) begin
            state_n = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (expire) begin
          state_n  = STOP;
          tmr_load = 1'b1;
        end
      end
      STOP: begin
        if (expire) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Frame configuration is captured once per frame so mid-frame changes
  // cannot corrupt it.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && fall) begin
      period_q <= period_in;
      bits_q   <= uart_eff_data_bits(data_bits);
      par_en_q <= parity_en;
      odd_q    <= odd_parity;
    end
    if ((state == START) && expire) begin
      shreg <= '0;
    end
    if ((state == DATA) && expire) begin
      shreg[bit_cnt] <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      par_acc    <= 1'b0;
      perr_q     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if ((state == START) && expire) begin
        bit_cnt <= '0;
        par_acc <= 1'b0;
        perr_q  <= 1'b0;
      end
      if ((state == DATA) && expire) begin
        bit_cnt <= bit_cnt + 3'd1;
        par_acc <= par_acc ^ rx_s;
      end
      // Expected parity bit is data XOR odd; any difference is an error.
      if ((state == PARITY) && expire) begin
        perr_q <= rx_s ^ par_acc ^ odd_q;
      end
      if ((state == STOP) && expire) begin
        rx_valid   <= 1'b1;
        rx_data    <= shreg;
        parity_err <= perr_q;
        frame_err  <= (rx_s != UART_STOP_BIT);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [31:0] baud_count;
  logic [3:0]  data_bits;
  logic        parity_en;
  logic        odd_parity;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        parity_err;
  logic        frame_err;
  logic        busy;

  uart_rx #(
    .SYNC_STAGES (SYNC),
    .BAUD_WIDTH  (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .baud_count (baud_count),
    .data_bits  (data_bits),
    .parity_en  (parity_en),
    .odd_parity (odd_parity),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         vcyc;
  } exp_t;

  exp_t q[$];

  // Scoreboard: every rx_valid must match the oldest expected frame.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("spurious_valid", 32'(rx_valid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rx_data", 32'(rx_data), 32'(e.d));
        check("parity_err", 32'(parity_err), 32'(e.pe));
        check("frame_err", 32'(frame_err), 32'(e.fe));
        check("valid_cycle", 32'(cyc), 32'(e.vcyc));
      end
    end
  end

  // Drives one frame starting in the current negedge interval and records
  // what the receiver must report and in which cycle.
  task automatic send_frame(input logic [7:0] d, input logic [3:0] db,
                            input logic pen, input logic podd, input logic bad,
                            input logic stop_val, input int baud, input int gap,
                            input bit scramble);
    int n, per;
    logic [7:0] m;
    logic pbit;
    exp_t e;
    n    = ((db >= 4'd5) && (db <= 4'd8)) ? int'(db) : 8;
    per  = (baud < 4) ? 4 : baud;
    m    = d & 8'((1 << n) - 1);
    pbit = (^m) ^ podd ^ bad;
    baud_count = 32'(baud);
    data_bits  = db;
    parity_en  = pen;
    odd_parity = podd;
    rx = 1'b0;
    e.d    = m;
    e.pe   = pen & bad;
    e.fe   = ~stop_val;
    // Edge seen SYNC cycles after the line drops; sample k at T0+half+k*per.
    e.vcyc = cyc + SYNC + per / 2 + (n + int'(pen) + 1) * per + 1;
    q.push_back(e);
    if (scramble) begin
      repeat (3) @(negedge clk);
      baud_count = $urandom;
      data_bits  = 4'($urandom);
      parity_en  = 1'($urandom);
      odd_parity = 1'($urandom);
      repeat (per - 3) @(negedge clk);
    end else begin
      repeat (per) @(negedge clk);
    end
    for (int i = 0; i < n; i++) begin
      rx = m[i];
      repeat (per) @(negedge clk);
    end
    if (pen) begin
      rx = pbit;
      repeat (per) @(negedge clk);
    end
    rx = stop_val;
    repeat (per) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1;
    rx = 1'b1;
    baud_count = 32'd16;
    data_bits = 4'd8;
    parity_en = 1'b0;
    odd_parity = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_parity_err", 32'(parity_err), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 0xA5
    send_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 16, 20, 1'b0);

    // 7E1 0x35, correct parity then inverted parity
    send_frame(8'h35, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 16, 10, 1'b0);
    send_frame(8'h35, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1, 16, 30, 1'b0);

    // Glitch: 3 low cycles; START sample at T0+8 sees high again
    baud_count = 32'd16;
    c = cyc;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (7) @(negedge clk);
    check("glitch_busy_start", 32'(busy), 32'd1);
    @(negedge clk);
    check("glitch_busy_idle", 32'(busy), 32'd0);
    check("glitch_cycle", 32'(cyc - c), 32'd11);
    repeat (40) @(negedge clk);

    // Break: stop bit low, line low for 40 bit times, then a 5O1 frame
    send_frame(8'h6C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 16, 0, 1'b0);
    rx = 1'b0;
    repeat (40 * 16) @(negedge clk);
    check("break_busy", 32'(busy), 32'd0);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    send_frame(8'h1B, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 16, 20, 1'b0);

    // Back-to-back 8N1 frames with no idle between them
    send_frame(8'h00, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 16, 0, 1'b0);
    send_frame(8'hFF, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 16, 40, 1'b0);
    check("b2b_drained", 32'(q.size()), 32'd0);

    // Reset during data bit 4 of a frame
    baud_count = 32'd16;
    data_bits  = 4'd8;
    parity_en  = 1'b0;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (16) @(negedge clk);
    end
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx = 1'b1;
    check("midrst_rx_data", 32'(rx_data), 32'd0);
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    check("midrst_parity_err", 32'(parity_err), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (12 * 16) @(negedge clk);
    send_frame(8'h5A, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 16, 20, 1'b0);

    // Randomised frames, including short/odd baud values, invalid bit
    // counts, parity errors, framing errors and mid-frame config changes.
    for (int k = 0; k < 24; k++) begin
      logic sv;
      int g;
      sv = ($urandom_range(0, 5) != 0);
      g  = $urandom_range(0, 20);
      if (!sv && g == 0) g = 1;
      send_frame(8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), sv, $urandom_range(0, 13), g,
                 1'($urandom));
    end

    repeat (300) @(negedge clk);
    check("pending_frames", 32'(q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver; the counterpart of the existing UART transmit path, sharing the same frame format and configuration fields.
- Frame: 1 start bit, 5–8 data bits sent LSB first, optional even/odd parity, 1 stop bit.
- Synchronises the serial line, detects the start bit, samples each bit mid-period and assembles the data word.
- Reports the word with one-cycle valid, parity-error and frame-error indications for the UART CSR block.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the rx input synchroniser (≥2)
BAUD_WIDTH, 32, width of the baud_count input

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line; idles high
baud_count  input  BAUD_WIDTH  clk cycles per bit; values <4 treated as 4
data_bits  input  4  data bits per frame (5..8); any other value treated as 8
parity_en  input  1  1 = a parity bit follows the data
odd_parity  input  1  1 = odd parity, 0 = even parity
rx_data  output  8  received word, right-aligned, upper bits zero
rx_valid  output  1  one-cycle pulse when a frame completes
parity_err  output  1  parity mismatch on last frame; valid while rx_valid=1 and held afterwards
frame_err  output  1  stop bit sampled low on last frame; same timing as parity_err
busy  output  1  high in every state other than IDLE

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset state:
  - state = IDLE; rx_data = 0; rx_valid = 0; parity_err = 0; frame_err = 0; busy = 0.
  - Synchroniser flops are loaded with 1; bit timer and bit counter are cleared.
- Reset mid-frame discards the partial frame and does not pulse rx_valid.
- rx_s is the synchronised line, delayed SYNC_STAGES cycles from rx.
- Start detection is a falling edge of rx_s (previous sample 1, current 0). A line held low never triggers a new frame until it has been seen high.
- On leaving IDLE, latch data_bits, parity_en, odd_parity and half = max(baud_count,4)>>1 (half period), plus the full period max(baud_count,4). Configuration changes mid-frame have no effect.
- Timer expiry: the timer reloads on each state entry; an expiry of N occurs N cycles after the load.
- FSM:
  - IDLE: falling edge → START; load the timer with half.
  - START: on expiry, sample rx_s.
    - rx_s=0 → DATA; load the timer with the full period; bit counter = 0.
    - rx_s=1 (glitch) → IDLE; no outputs change.
  - DATA: on each expiry, shift rx_s into the data register (LSB first) and increment the bit counter.
    - After the n-th bit → PARITY if parity_en, else STOP.
    - The timer reloads with the full period each bit.
  - PARITY: on expiry, sample the parity bit.
    - expected = (XOR of n data bits) XOR odd_parity.
    - Record mismatch; → STOP.
  - STOP: on expiry, sample the stop bit.
    - Next cycle: rx_valid=1; rx_data, parity_err and frame_err update to this frame's values; frame_err = ~stop sample.
    - Same cycle: → IDLE.
- Sample timing relative to the cycle T0 in which the falling edge is seen: start sample at T0+half; sample k at T0+half+k·period; the stop sample is at k = n+parity_en+1. rx_valid is high at the cycle after the stop sample.
- When parity_en=0, parity_err=0.
- Back-to-back frames: returning to IDLE at mid-stop allows the next start edge to be caught with no lost frames.
- rx_data and the error flags hold until the next rx_valid; there is no overrun tracking (the consumer must take the data within one frame).

Decomposition:
- UART_pkg:
  - add uart_rx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - reuse uart_data_t, UART_START_BIT, UART_STOP_BIT;
  - add UART_MIN_BAUD_COUNT = 4.
- Sub-module uart_rx_bit_timer: loadable down-counter (load value, load strobe, enable, expire pulse), synchronous active-high reset. Everything else (synchroniser, FSM, shift register, parity) stays in uart_rx.

Test Plan:
- 8N1 frame: baud_count=16, send 0xA5. Required: rx_data=0xA5; one rx_valid pulse at T0+8+9·16+1; parity_err=0; frame_err=0.
- 7E1 frame: data_bits=7, parity_en=1, odd_parity=0, send 0x35 with correct parity, then 0x35 with inverted parity. Required: parity_err=0 on the first frame, 1 on the second; rx_data=0x35 both times.
- Glitch: rx low for 3 cycles with baud_count=16. Required: busy returns to 0 after the START sample; no rx_valid.
- Framing/break: stop bit driven 0, then line held low for 40 bit times, then high, then a valid 5O1 frame carrying 0x1B. Required:
  - frame_err=1 on the first rx_valid;
  - no rx_valid during the low period;
  - second frame gives rx_data=0x1B (bits[7:5]=0), frame_err=0, parity_err=0.
- Back-to-back: two 8N1 frames 0x00 and 0xFF with zero idle between them. Required: two rx_valid pulses exactly 10·16 cycles apart with the correct data.
- Reset mid-frame: assert rst during DATA bit 4 for 1 cycle. Required: all outputs 0 the next cycle; no rx_valid; the following frame 0x5A is received correctly.
